// File: rtl/pipe_stage_bank.sv
// Parametrised pipeline register bank: DEPTH stages of payload + control with per-stage valid,
// supporting stall (hold), flush (bubble insertion) and control zeroing on bubbles.
module pipe_stage_bank #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  v;
  logic [DATA_W-1:0] d [DEPTH];
  logic [CTRL_W-1:0] c [DEPTH];
  logic [OCC_W-1:0]  occ;

  // Control is cleared with valid on flush so a bubble can never carry live write enables;
  // payload is left alone because nothing downstream trusts it without valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
    end else if (flush) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        c[i] <= '0;
      end
    end else if (!stall) begin
      v[0] <= in_valid;
      d[0] <= in_data;
      c[0] <= in_valid ? in_ctrl : '0;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
        c[i] <= c[i-1];
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(v[i]);
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_ctrl  = c[DEPTH-1];
  assign occupancy = occ;
  assign busy      = |v;

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Directed and randomised checks of pipe_stage_bank at DEPTH 1, 2 and 3 sharing one input stream.
module tb_pipe_stage_bank;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;

  logic        ov1, ov2, ov3, busy1, busy2, busy3;
  logic [31:0] od1, od2, od3;
  logic [7:0]  oc1, oc2, oc3;
  logic        occ1;
  logic [1:0]  occ2, occ3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_bank #(.DATA_W(32), .CTRL_W(8), .DEPTH(1)) u1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov1), .out_data(od1),
    .out_ctrl(oc1), .busy(busy1), .occupancy(occ1));

  pipe_stage_bank #(.DATA_W(32), .CTRL_W(8), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov2), .out_data(od2),
    .out_ctrl(oc2), .busy(busy2), .occupancy(occ2));

  pipe_stage_bank #(.DATA_W(32), .CTRL_W(8), .DEPTH(3)) u3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov3), .out_data(od3),
    .out_ctrl(oc3), .busy(busy3), .occupancy(occ3));

  // Inputs set before step() are captured on its edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0; in_valid = 0; in_data = 0; in_ctrl = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ov3, od3, oc3, busy3, occ3} !== 44'd0) begin
      failures++;
      $display("[TB] FAIL reset_initial got v=%b d=%h c=%h busy=%b occ=%0d want all zero",
               ov3, od3, oc3, busy3, occ3);
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_data = 32'h100 + k; in_ctrl = 8'h11;
      step();
    end
    checks++;
    if (occ3 !== 2'd3 || od3 !== 32'h100 || oc3 !== 8'h11 || busy3 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fill_before_reset got occ=%0d d=%h c=%h busy=%b want 3 00000100 11 1",
               occ3, od3, oc3, busy3);
    end
    reset = 1;
    step();
    idle_inputs();
    checks++;
    if ({ov3, od3, oc3, busy3, occ3} !== 44'd0 || {ov2, busy2, occ2} !== 4'd0 || {ov1, occ1} !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_midstream got v=%b d=%h c=%h busy=%b occ=%0d want all zero",
               ov3, od3, oc3, busy3, occ3);
    end
  endtask

  task automatic test_latency();
    do_reset();
    in_valid = 1; in_data = 32'hDEADBEEF; in_ctrl = 8'h5A;
    step();
    idle_inputs();
    checks++;
    if (ov1 !== 1'b1 || od1 !== 32'hDEADBEEF || oc1 !== 8'h5A || ov3 !== 1'b0 || occ3 !== 2'd1) begin
      failures++;
      $display("[TB] FAIL latency_edge0 got d1v=%b d1=%h c1=%h d3v=%b occ3=%0d want 1 deadbeef 5a 0 1",
               ov1, od1, oc1, ov3, occ3);
    end
    step();
    checks++;
    if (ov3 !== 1'b0 || ov1 !== 1'b0 || oc1 !== 8'h00) begin
      failures++;
      $display("[TB] FAIL latency_edge1 got d3v=%b d1v=%b c1=%h want 0 0 00", ov3, ov1, oc1);
    end
    step();
    checks++;
    if (ov3 !== 1'b1 || od3 !== 32'hDEADBEEF || oc3 !== 8'h5A || occ3 !== 2'd1) begin
      failures++;
      $display("[TB] FAIL latency_edge2 got v=%b d=%h c=%h occ=%0d want 1 deadbeef 5a 1",
               ov3, od3, oc3, occ3);
    end
    step();
    checks++;
    if (ov3 !== 1'b0 || oc3 !== 8'h00 || busy3 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_edge3 got v=%b c=%h busy=%b want 0 00 0", ov3, oc3, busy3);
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1; in_data = 32'h1; in_ctrl = 8'h0A;
    step();
    in_data = 32'h2; in_ctrl = 8'h0B;
    step();
    checks++;
    if (ov2 !== 1'b1 || od2 !== 32'h1 || oc2 !== 8'h0A || occ2 !== 2'd2) begin
      failures++;
      $display("[TB] FAIL stall_prefill got v=%b d=%h c=%h occ=%0d want 1 00000001 0a 2",
               ov2, od2, oc2, occ2);
    end
    stall = 1; in_data = 32'h3; in_ctrl = 8'h0C;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (ov2 !== 1'b1 || od2 !== 32'h1 || oc2 !== 8'h0A || occ2 !== 2'd2 || busy2 !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_hold%0d got v=%b d=%h c=%h occ=%0d want 1 00000001 0a 2",
                 k, ov2, od2, oc2, occ2);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (ov2 !== 1'b1 || od2 !== 32'h2 || oc2 !== 8'h0B || occ2 !== 2'd1) begin
      failures++;
      $display("[TB] FAIL stall_release got v=%b d=%h c=%h occ=%0d want 1 00000002 0b 1",
               ov2, od2, oc2, occ2);
    end
    step();
    checks++;
    if (ov2 !== 1'b0 || oc2 !== 8'h00 || occ2 !== 2'd0) begin
      failures++;
      $display("[TB] FAIL stall_drain got v=%b c=%h occ=%0d want 0 00 0", ov2, oc2, occ2);
    end
  endtask

  task automatic test_flush_vs_stall();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_data = 32'hA0 + k; in_ctrl = 8'hFF;
      step();
    end
    checks++;
    if (occ3 !== 2'd3 || oc3 !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL flush_prefill got occ=%0d c=%h want 3 ff", occ3, oc3);
    end
    flush = 1; stall = 1; in_data = 32'h55;
    step();
    idle_inputs();
    checks++;
    if (occ3 !== 2'd0 || busy3 !== 1'b0 || oc3 !== 8'h00 || ov3 !== 1'b0 || od3 !== 32'hA0) begin
      failures++;
      $display("[TB] FAIL flush_with_stall got occ=%0d busy=%b c=%h v=%b d=%h want 0 0 00 0 000000a0",
               occ3, busy3, oc3, ov3, od3);
    end
    checks++;
    if (ov1 !== 1'b0 || oc1 !== 8'h00 || occ1 !== 1'b0 || od1 !== 32'hA2) begin
      failures++;
      $display("[TB] FAIL flush_depth1 got v=%b c=%h occ=%0d d=%h want 0 00 0 000000a2",
               ov1, oc1, occ1, od1);
    end
  endtask

  task automatic test_bubble_ctrl();
    do_reset();
    in_valid = 0; in_data = 32'h77; in_ctrl = 8'hFF;
    step();
    checks++;
    if (ov1 !== 1'b0 || oc1 !== 8'h00 || od1 !== 32'h77) begin
      failures++;
      $display("[TB] FAIL bubble_depth1 got v=%b c=%h d=%h want 0 00 00000077", ov1, oc1, od1);
    end
    step();
    step();
    checks++;
    if (ov3 !== 1'b0 || oc3 !== 8'h00 || od3 !== 32'h77 || busy3 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bubble_depth3 got v=%b c=%h d=%h busy=%b want 0 00 00000077 0",
               ov3, oc3, od3, busy3);
    end
    idle_inputs();
  endtask

  // Reference for DEPTH=3: stage contents tracked independently from the DUT.
  task automatic test_random();
    logic        mv [3];
    logic [31:0] md [3];
    logic [7:0]  mc [3];
    logic [1:0]  mocc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0; md[i] = 0; mc[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset    = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      in_valid = $urandom_range(0, 1);
      in_data  = $urandom;
      in_ctrl  = 8'($urandom);
      if (reset) begin
        for (int i = 0; i < 3; i++) begin
          mv[i] = 0; md[i] = 0; mc[i] = 0;
        end
      end else if (flush) begin
        for (int i = 0; i < 3; i++) begin
          mv[i] = 0; mc[i] = 0;
        end
      end else if (!stall) begin
        mv[2] = mv[1]; md[2] = md[1]; mc[2] = mc[1];
        mv[1] = mv[0]; md[1] = md[0]; mc[1] = mc[0];
        mv[0] = in_valid; md[0] = in_data; mc[0] = in_valid ? in_ctrl : 8'h00;
      end
      step();
      mocc = 2'(mv[0]) + 2'(mv[1]) + 2'(mv[2]);
      checks++;
      if (ov3 !== mv[2] || od3 !== md[2] || oc3 !== mc[2] || occ3 !== mocc ||
          busy3 !== (mocc != 0) || (ov3 === 1'b0 && oc3 !== 8'h00)) begin
        failures++;
        $display("[TB] FAIL random_cyc%0d got v=%b d=%h c=%h occ=%0d busy=%b want v=%b d=%h c=%h occ=%0d",
                 cyc, ov3, od3, oc3, occ3, busy3, mv[2], md[2], mc[2], mocc);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_latency();
    test_stall();
    test_flush_vs_stall();
    test_bubble_ctrl();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
